// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU operand register stage between
// two requesters and returns the captured result over valid/ready.
module alu_req_arbiter #(
   parameter int N       = 4,
   parameter int OPW     = 3,
   parameter int ALU_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0,
   input  logic [N-1:0]   a0,
   input  logic [N-1:0]   b0,
   input  logic [OPW-1:0] op0,
   input  logic           req1,
   input  logic [N-1:0]   a1,
   input  logic [N-1:0]   b1,
   input  logic [OPW-1:0] op1,
   output logic           gnt0,
   output logic           gnt1,
   output logic [N-1:0]   reg_a,
   output logic [N-1:0]   reg_b,
   output logic [OPW-1:0] reg_op,
   input  logic [N-1:0]   alu_y,
   input  logic [3:0]     alu_flags,
   output logic [N-1:0]   res_y,
   output logic [3:0]     res_flags,
   output logic           res_id,
   output logic           res_valid,
   input  logic           res_ready,
   output logic           busy
);

   localparam int CW = $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last_gnt;
   logic          win1;

   // requester 1 wins alone, or on a tie when requester 0 went last
   assign win1 = req1 & (~req0 | ~last_gnt);
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         last_gnt  <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         reg_a     <= '0;
         reg_b     <= '0;
         reg_op    <= '0;
         res_y     <= '0;
         res_flags <= '0;
         res_id    <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  gnt0     <= ~win1;
                  gnt1     <= win1;
                  last_gnt <= win1;
                  res_id   <= win1;
                  reg_a    <= win1 ? a1 : a0;
                  reg_b    <= win1 ? b1 : b0;
                  reg_op   <= win1 ? op1 : op0;
                  cnt      <= CW'(ALU_LAT);
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == CW'(1)) begin
                  cnt       <= '0;
                  res_y     <= alu_y;
                  res_flags <= alu_flags;
                  res_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: ALU_LAT=1 instance for arbitration
// and handshake, ALU_LAT=3 instance for latency.
module tb_alu_req_arbiter;

   localparam int N   = 4;
   localparam int OPW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic           req0, req1, gnt0, gnt1, res_id, res_valid, res_ready, busy;
   logic [N-1:0]   a0, b0, a1, b1, reg_a, reg_b, alu_y, res_y;
   logic [OPW-1:0] op0, op1, reg_op;
   logic [3:0]     alu_flags, res_flags;

   logic           s_req0, s_req1, s_gnt0, s_gnt1, s_res_id, s_res_valid;
   logic           s_res_ready, s_busy;
   logic [N-1:0]   s_a0, s_b0, s_a1, s_b1, s_reg_a, s_reg_b, s_alu_y, s_res_y;
   logic [OPW-1:0] s_op0, s_op1, s_reg_op;
   logic [3:0]     s_alu_flags, s_res_flags;

   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
      logic [4:0] s;
      logic [3:0] y;
      logic       c, v;
      s = '0;
      y = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            y = s[3:0];
            c = s[4];
            v = (a[3] == b[3]) && (y[3] != a[3]);
         end
         3'd1: begin
            s = {1'b0, a} - {1'b0, b};
            y = s[3:0];
            c = s[4];
            v = (a[3] != b[3]) && (y[3] != a[3]);
         end
         3'd2:    y = a & b;
         default: y = a ^ b;
      endcase
      return {y[3], (y == 4'h0), c, v, y};
   endfunction

   assign {alu_flags, alu_y}     = alu_f(reg_a, reg_b, reg_op);
   assign {s_alu_flags, s_alu_y} = alu_f(s_reg_a, s_reg_b, s_reg_op);

   alu_req_arbiter #(.N(N), .OPW(OPW), .ALU_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0), .op0(op0),
      .req1(req1), .a1(a1), .b1(b1), .op1(op1),
      .gnt0(gnt0), .gnt1(gnt1),
      .reg_a(reg_a), .reg_b(reg_b), .reg_op(reg_op),
      .alu_y(alu_y), .alu_flags(alu_flags),
      .res_y(res_y), .res_flags(res_flags), .res_id(res_id),
      .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
   );

   alu_req_arbiter #(.N(N), .OPW(OPW), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .req0(s_req0), .a0(s_a0), .b0(s_b0), .op0(s_op0),
      .req1(s_req1), .a1(s_a1), .b1(s_b1), .op1(s_op1),
      .gnt0(s_gnt0), .gnt1(s_gnt1),
      .reg_a(s_reg_a), .reg_b(s_reg_b), .reg_op(s_reg_op),
      .alu_y(s_alu_y), .alu_flags(s_alu_flags),
      .res_y(s_res_y), .res_flags(s_res_flags), .res_id(s_res_id),
      .res_valid(s_res_valid), .res_ready(s_res_ready), .busy(s_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected grant owner per grant, expected {id,flags,y} per result
   logic       gq[$];
   logic [8:0] rq[$];
   logic       gprev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         gprev = 1'b0;
      end else begin
         if (gnt0 || gnt1) begin
            chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 0);
            chk("gnt_pulse", {31'd0, gprev}, 0);
            if (gq.size() == 0) chk("gnt_unexpected", {31'd0, gnt0 | gnt1}, 0);
            else chk("gnt_order", {31'd0, gnt1}, {31'd0, gq.pop_front()});
         end
         gprev = gnt0 | gnt1;
         if (res_valid && res_ready) begin
            if (rq.size() == 0) chk("res_unexpected", {31'd0, res_valid}, 0);
            else chk("res", {23'd0, res_id, res_flags, res_y},
                     {23'd0, rq.pop_front()});
         end
      end
   end

   function automatic logic [23:0] outs1();
      return {gnt0, gnt1, reg_a, reg_b, reg_op, res_y, res_flags,
              res_id, res_valid, busy};
   endfunction

   function automatic logic [23:0] outs3();
      return {s_gnt0, s_gnt1, s_reg_a, s_reg_b, s_reg_op, s_res_y,
              s_res_flags, s_res_id, s_res_valid, s_busy};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      req0 = 0; a0 = '0; b0 = '0; op0 = '0;
      req1 = 0; a1 = '0; b1 = '0; op1 = '0;
      res_ready = 1;
      s_req0 = 0; s_a0 = '0; s_b0 = '0; s_op0 = '0;
      s_req1 = 0; s_a1 = '0; s_b1 = '0; s_op1 = '0;
      s_res_ready = 1;

      #2;
      chk("rst_outs", {8'd0, outs1()}, 0);
      chk("rst_outs3", {8'd0, outs3()}, 0);
      step();
      step();
      rst = 0;

      // reset while an operation is in WAIT
      a0 = 4'h6; b0 = 4'h2; op0 = 3'd0; req0 = 1;
      step();
      chk("t1_gnt0", {31'd0, gnt0}, 1);
      chk("t1_reg_a", {28'd0, reg_a}, 4'h6);
      #1 rst = 1;
      #1;
      chk("t1_async_outs", {8'd0, outs1()}, 0);
      chk("t1_busy", {31'd0, busy}, 0);
      req0 = 0;
      step();
      step();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_no_res", {30'd0, res_valid, busy}, 0);
      end

      // tie: both held for three operations -> 0,1,0
      a0 = 4'h2; b0 = 4'h3; op0 = 3'd0;
      a1 = 4'h7; b1 = 4'h1; op1 = 3'd0;
      gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
      rq.push_back({1'b0, 4'b0000, 4'h5});
      rq.push_back({1'b1, 4'b1001, 4'h8});
      rq.push_back({1'b0, 4'b0000, 4'h5});
      req0 = 1; req1 = 1;
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         step();
         if (gnt0 || gnt1) n++;
      end
      req0 = 0; req1 = 0;
      chk("t3_grants", n, 3);
      repeat (4) step();

      // single op
      a0 = 4'h3; b0 = 4'h5; op0 = 3'd0;
      gq.push_back(1'b0);
      rq.push_back({1'b0, 4'b1001, 4'h8});
      req0 = 1;
      step();
      chk("t2_gnt0", {31'd0, gnt0}, 1);
      chk("t2_regs", {21'd0, reg_a, reg_b, reg_op}, {21'd0, 4'h3, 4'h5, 3'd0});
      req0 = 0;
      step();
      chk("t2_valid", {31'd0, res_valid}, 1);
      chk("t2_res", {27'd0, res_id, res_y}, {27'd0, 1'b0, 4'h8});
      repeat (2) step();

      // backpressure, with req1 rising during WAIT
      res_ready = 0;
      a0 = 4'h9; b0 = 4'h9; op0 = 3'd0;
      gq.push_back(1'b0);
      rq.push_back({1'b0, 4'b0011, 4'h2});
      req0 = 1;
      step();
      chk("t4_gnt0", {31'd0, gnt0}, 1);
      req0 = 0;
      a1 = 4'h1; b1 = 4'h1; op1 = 3'd2; req1 = 1;
      step();
      chk("t6_no_gnt1_wait", {31'd0, gnt1}, 0);
      chk("t4_valid", {31'd0, res_valid}, 1);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            a1 = 4'h4; b1 = 4'h4;
         end
         step();
         chk("t4_hold", {22'd0, res_valid, res_id, res_flags, res_y, gnt1},
             {22'd0, 1'b1, 1'b0, 4'b0011, 4'h2, 1'b0});
      end
      gq.push_back(1'b1);
      rq.push_back({1'b1, 4'b0000, 4'h4});
      res_ready = 1;
      step();
      chk("t4_release", {29'd0, res_valid, gnt1, busy}, 0);
      step();
      chk("t6_gnt1", {31'd0, gnt1}, 1);
      chk("t6_regs", {21'd0, reg_a, reg_b, reg_op}, {21'd0, 4'h4, 4'h4, 3'd2});
      req1 = 0;
      repeat (3) step();

      // ALU_LAT=3 latency
      s_a1 = 4'hF; s_b1 = 4'h1; s_op1 = 3'd0; s_req1 = 1;
      step();
      chk("t5_gnt1", {30'd0, s_gnt1, s_busy}, 3);
      s_req1 = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t5_not_yet", {31'd0, s_res_valid}, 0);
      end
      step();
      chk("t5_valid", {31'd0, s_res_valid}, 1);
      chk("t5_res", {23'd0, s_res_id, s_res_flags, s_res_y},
          {23'd0, 1'b1, 4'b0110, 4'h0});
      repeat (3) step();

      chk("gq_drained", gq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
